spim_scheduler: RTL and testbench

SPIM_SCHEDULER -- requirements
Module: spim_scheduler

---
 rtl/spim_scheduler_if.sv | 22 ++
 rtl/spim_scheduler.sv | 174 +++++++++++++++++
 tb/tb_spim_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spim_scheduler_if.sv
// Register-port bus between the transaction scheduler and the SPI master core.
// The scheduler drives the strobes, address and write data; the SPI master returns read data and status.
interface spim_scheduler_if;
    logic        spi_select;
    logic        read_n;
    logic        write_n;
    logic [2:0]  mem_addr;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;
    logic        spi_txrdy;
    logic        spi_rxrdy;

    modport master (
        output spi_select, read_n, write_n, mem_addr, spi_wdata,
        input  spi_rdata, spi_txrdy, spi_rxrdy
    );

    modport slave (
        input  spi_select, read_n, write_n, mem_addr, spi_wdata,
        output spi_rdata, spi_txrdy, spi_rxrdy
    );
endinterface

// File: rtl/spim_scheduler.sv
// Two-requester scheduler that runs 1..4 byte SPI transactions through the register port of an SPI master.
// Each register access uses two strobe cycles followed by one idle cycle.
module spim_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [15:0]      req0_ss,
    input  logic [1:0]       req0_len,
    input  logic [31:0]      req0_tx,
    output logic             req0_ack,
    output logic             req0_done,
    output logic [31:0]      req0_rx,
    output logic             req0_err,
    input  logic             req1_valid,
    input  logic [15:0]      req1_ss,
    input  logic [1:0]       req1_len,
    input  logic [31:0]      req1_tx,
    output logic             req1_ack,
    output logic             req1_done,
    output logic [31:0]      req1_rx,
    output logic             req1_err,
    output logic             busy,
    spim_scheduler_if.master spi
);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, ARB, SS, SSO_ON, TXWAIT, TXWR, RXWAIT, RXRD, SSO_OFF, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          acc_ph;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [1:0]          byte_cnt;
    logic [1:0]          len_q;
    logic                grant_q, grant_nxt;
    logic [15:0]         ss_q;
    logic [31:0]         tx_q;
    logic [31:0]         rx_sh;
    logic                err_q;
    logic [2:0]          addr;
    logic [15:0]         wdata;

    logic any_req, is_acc, acc_on, acc_end, wait_hit, tmo;

    assign any_req  = req0_valid | req1_valid;
    assign is_acc   = state inside {SS, SSO_ON, TXWR, RXRD, SSO_OFF};
    assign acc_on   = is_acc && (acc_ph != 2'd2);
    assign acc_end  = is_acc && (acc_ph == 2'd2);
    assign wait_hit = (wait_cnt == WCNT_W'(TIMEOUT - 1));
    // A ready seen on the final wait cycle still wins over the timeout.
    assign tmo      = ((state == TXWAIT) && !spi.spi_txrdy && wait_hit) ||
                      ((state == RXWAIT) && !spi.spi_rxrdy && wait_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        addr      = 3'd0;
        wdata     = 16'h0000;
        req0_ack  = 1'b0;
        req1_ack  = 1'b0;
        req0_done = 1'b0;
        req1_done = 1'b0;
        case (state)
            IDLE:    if (any_req) state_nxt = ARB;
            ARB: begin
                if (any_req) begin
                    grant_nxt = (req0_valid && req1_valid) ? ~grant_q : req1_valid;
                    req0_ack  = ~grant_nxt;
                    req1_ack  = grant_nxt;
                    state_nxt = SS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SS: begin
                addr  = 3'd5;
                wdata = ss_q;
                if (acc_end) state_nxt = SSO_ON;
            end
            SSO_ON: begin
                addr  = 3'd3;
                wdata = 16'h0400;
                if (acc_end) state_nxt = TXWAIT;
            end
            TXWAIT: begin
                if (spi.spi_txrdy) state_nxt = TXWR;
                else if (wait_hit) state_nxt = SSO_OFF;
            end
            TXWR: begin
                addr  = 3'd1;
                wdata = {8'h00, tx_q[31:24]};
                if (acc_end) state_nxt = RXWAIT;
            end
            RXWAIT: begin
                if (spi.spi_rxrdy) state_nxt = RXRD;
                else if (wait_hit) state_nxt = SSO_OFF;
            end
            RXRD: begin
                addr = 3'd0;
                if (acc_end) state_nxt = (byte_cnt == len_q) ? SSO_OFF : TXWAIT;
            end
            SSO_OFF: begin
                addr  = 3'd3;
                wdata = 16'h0000;
                if (acc_end) state_nxt = DONE;
            end
            DONE: begin
                req0_done = ~grant_q;
                req1_done = grant_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        spi.spi_select = acc_on;
        spi.read_n     = !(acc_on && (state == RXRD));
        spi.write_n    = !(acc_on && (state != RXRD));
        spi.mem_addr   = acc_on ? addr : 3'd0;
        spi.spi_wdata  = acc_on ? wdata : 16'h0000;
        busy           = ((state == ARB) && any_req) || !(state inside {IDLE, ARB});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_ph   <= 2'd0;
            wait_cnt <= '0;
            byte_cnt <= 2'd0;
            len_q    <= 2'd0;
            grant_q  <= 1'b1;
            ss_q     <= 16'h0000;
            tx_q     <= 32'h0;
            rx_sh    <= 32'h0;
            err_q    <= 1'b0;
            req0_rx  <= 32'h0;
            req1_rx  <= 32'h0;
            req0_err <= 1'b0;
            req1_err <= 1'b0;
        end else begin
            acc_ph   <= (is_acc && !acc_end) ? acc_ph + 2'd1 : 2'd0;
            // Every wait state is entered from an access state, so clearing outside waits resets it on entry.
            wait_cnt <= (state inside {TXWAIT, RXWAIT}) ? wait_cnt + 1'b1 : '0;
            if (state == ARB && any_req) begin
                grant_q  <= grant_nxt;
                ss_q     <= grant_nxt ? req1_ss  : req0_ss;
                len_q    <= grant_nxt ? req1_len : req0_len;
                tx_q     <= grant_nxt ? req1_tx  : req0_tx;
                byte_cnt <= 2'd0;
                rx_sh    <= 32'h0;
                err_q    <= 1'b0;
            end
            if (state == TXWR && acc_end) tx_q <= {tx_q[23:0], 8'h00};
            if (state == RXRD && acc_ph == 2'd1) rx_sh <= {rx_sh[23:0], spi.spi_rdata[7:0]};
            if (state == RXRD && acc_end && byte_cnt != len_q) byte_cnt <= byte_cnt + 2'd1;
            if (tmo) err_q <= 1'b1;
            // Results are published on entry to DONE so they are valid alongside the done pulse.
            if (state == SSO_OFF && acc_end) begin
                if (grant_q) begin
                    req1_rx  <= rx_sh;
                    req1_err <= err_q;
                end else begin
                    req0_rx  <= rx_sh;
                    req0_err <= err_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_spim_scheduler.sv
// Scoreboard bench for spim_scheduler: an SPI-master register model, expected-access/ack/done queues and monitors.
module tb_spim_scheduler;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_ss = '0, req1_ss = '0;
    logic [1:0]  req0_len = '0, req1_len = '0;
    logic [31:0] req0_tx = '0, req1_tx = '0;
    logic        req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err, busy;
    logic [31:0] req0_rx, req1_rx;

    spim_scheduler_if spi_bus();

    spim_scheduler #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ss(req0_ss), .req0_len(req0_len), .req0_tx(req0_tx),
        .req0_ack(req0_ack), .req0_done(req0_done), .req0_rx(req0_rx), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ss(req1_ss), .req1_len(req1_len), .req1_tx(req1_tx),
        .req1_ack(req1_ack), .req1_done(req1_done), .req1_rx(req1_rx), .req1_err(req1_err),
        .busy(busy), .spi(spi_bus)
    );

    typedef struct {
        bit        rd;
        bit [2:0]  addr;
        bit [15:0] data;
        int        gap;
    } acc_t;
    typedef struct {
        bit        who;
        bit [31:0] rx;
        bit        err;
    } done_t;

    acc_t       exp_acc[$];
    done_t      exp_done[$];
    bit         exp_ack[$];
    logic [7:0] rx_bytes[$];

    int errors = 0;
    int checks = 0;
    int n_ack = 0;
    int n_done = 0;

    logic txrdy_en = 1'b1;
    logic rxrdy_en = 1'b1;
    logic rx_pend = 1'b0;
    logic [7:0] rd_byte = 8'h00;

    assign spi_bus.spi_txrdy = txrdy_en;
    assign spi_bus.spi_rxrdy = rx_pend && rxrdy_en;
    assign spi_bus.spi_rdata = {8'h00, rd_byte};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SPI master model plus access protocol monitor
    int         run = 0, idle_run = 0, gap_s = 0;
    logic       rd_s, stable;
    logic [2:0] addr_s;
    logic [15:0] data_s;
    always @(negedge clk) begin
        logic act;
        acc_t e;
        act = spi_bus.spi_select && (!spi_bus.read_n || !spi_bus.write_n);
        if (reset_n && act) begin
            if (run == 0) begin
                gap_s  = idle_run;
                rd_s   = !spi_bus.read_n;
                addr_s = spi_bus.mem_addr;
                data_s = spi_bus.spi_wdata;
                stable = 1'b1;
            end else if (rd_s != !spi_bus.read_n || addr_s != spi_bus.mem_addr || data_s != spi_bus.spi_wdata) begin
                stable = 1'b0;
            end
            if (!spi_bus.read_n && !spi_bus.write_n) stable = 1'b0;
            run++;
            idle_run = 0;
        end else begin
            if (run > 0) begin
                check("access_cycles", 32'(run), 32'd2);
                check("access_stable", {31'd0, stable}, 32'd1);
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: got addr %0d data %h rd %0d, expected none", addr_s, data_s, rd_s);
                end else begin
                    e = exp_acc.pop_front();
                    check("acc_rd", {31'd0, rd_s}, {31'd0, e.rd});
                    check("acc_addr", {29'd0, addr_s}, {29'd0, e.addr});
                    check("acc_data", {16'd0, data_s}, {16'd0, e.data});
                    if (e.gap >= 0) check("acc_gap", 32'(gap_s), 32'(e.gap));
                end
                if (rd_s) begin
                    if (rx_bytes.size() > 0) void'(rx_bytes.pop_front());
                    rx_pend = 1'b0;
                end else if (addr_s == 3'd1) begin
                    rx_pend = 1'b1;
                end else if (addr_s == 3'd5) begin
                    rx_pend = 1'b0;
                end
            end
            run = 0;
            idle_run++;
        end
        rd_byte = (rx_bytes.size() > 0) ? rx_bytes[0] : 8'h00;
    end

    // Ack/done monitor
    always @(negedge clk) begin
        bit    b;
        done_t d;
        if (req0_ack || req1_ack) begin
            n_ack++;
            check("ack_onehot", {31'd0, req0_ack && req1_ack}, 32'd0);
            if (exp_ack.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, expected none", req0_ack, req1_ack);
            end else begin
                b = exp_ack.pop_front();
                check("ack_who", {31'd0, req1_ack}, {31'd0, b});
            end
        end
        if (req0_done || req1_done) begin
            n_done++;
            check("done_busy", {31'd0, busy}, 32'd1);
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done0=%0d done1=%0d, expected none", req0_done, req1_done);
            end else begin
                d = exp_done.pop_front();
                check("done_who", {31'd0, req1_done}, {31'd0, d.who});
                check("done_rx", d.who ? req1_rx : req0_rx, d.rx);
                check("done_err", {31'd0, d.who ? req1_err : req0_err}, {31'd0, d.err});
            end
        end
    end

    task automatic push_txn(input logic [15:0] ss, input int len, input logic [31:0] tx);
        exp_acc.push_back('{1'b0, 3'd5, ss, -1});
        exp_acc.push_back('{1'b0, 3'd3, 16'h0400, 1});
        for (int i = 0; i <= len; i++) begin
            exp_acc.push_back('{1'b0, 3'd1, {8'h00, tx[31-8*i -: 8]}, -1});
            exp_acc.push_back('{1'b1, 3'd0, 16'h0000, -1});
        end
        exp_acc.push_back('{1'b0, 3'd3, 16'h0000, 1});
    endtask

    task automatic request(input bit who, input logic [15:0] ss, input logic [1:0] len, input logic [31:0] tx);
        int c;
        @(negedge clk);
        if (who) begin
            req1_ss = ss; req1_len = len; req1_tx = tx; req1_valid = 1'b1;
        end else begin
            req0_ss = ss; req0_len = len; req0_tx = tx; req0_valid = 1'b1;
        end
        c = 0;
        while (!(who ? req1_ack : req0_ack) && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("ack_wait", {31'd0, who ? req1_ack : req0_ack}, 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int c;
        c = 0;
        while (n_done < target && c < limit) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check("done_count", 32'(n_done), 32'(target));
    endtask

    initial begin
        int c, a0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {30'd0, req1_ack, req0_ack}, 32'd0);
        check("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
        check("rst_strobes", {29'd0, spi_bus.spi_select, spi_bus.read_n, spi_bus.write_n}, 32'd3);
        check("rst_addr_data", {13'd0, spi_bus.mem_addr, spi_bus.spi_wdata}, 32'd0);
        check("rst_rx0", req0_rx, 32'd0);
        check("rst_rx1", req1_rx, 32'd0);
        check("rst_err", {30'd0, req1_err, req0_err}, 32'd0);
        reset_n = 1'b1;

        // Single byte on req0
        rx_bytes.push_back(8'h3C);
        push_txn(16'h0001, 0, 32'hA500_0000);
        exp_ack.push_back(1'b0);
        exp_done.push_back('{1'b0, 32'h0000_003C, 1'b0});
        request(1'b0, 16'h0001, 2'd0, 32'hA500_0000);
        wait_done(1, 200);

        // Four bytes on req1
        rx_bytes.push_back(8'h11); rx_bytes.push_back(8'h22);
        rx_bytes.push_back(8'h33); rx_bytes.push_back(8'h44);
        push_txn(16'h0002, 3, 32'h0102_0304);
        exp_ack.push_back(1'b1);
        exp_done.push_back('{1'b1, 32'h1122_3344, 1'b0});
        request(1'b1, 16'h0002, 2'd3, 32'h0102_0304);
        wait_done(2, 400);

        // Round robin from reset with both requesters held
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        rx_bytes.push_back(8'h10); rx_bytes.push_back(8'h20);
        rx_bytes.push_back(8'h30); rx_bytes.push_back(8'h40);
        for (int k = 0; k < 2; k++) begin
            push_txn(16'h0001, 0, 32'h5A00_0000);
            push_txn(16'h0002, 0, 32'hC300_0000);
            exp_ack.push_back(1'b0);
            exp_ack.push_back(1'b1);
        end
        exp_done.push_back('{1'b0, 32'h0000_0010, 1'b0});
        exp_done.push_back('{1'b1, 32'h0000_0020, 1'b0});
        exp_done.push_back('{1'b0, 32'h0000_0030, 1'b0});
        exp_done.push_back('{1'b1, 32'h0000_0040, 1'b0});
        @(negedge clk);
        req0_ss = 16'h0001; req0_len = 2'd0; req0_tx = 32'h5A00_0000; req0_valid = 1'b1;
        req1_ss = 16'h0002; req1_len = 2'd0; req1_tx = 32'hC300_0000; req1_valid = 1'b1;
        a0 = 0;
        c = 0;
        while (a0 < 4 && c < 400) begin
            @(negedge clk);
            if (req0_ack || req1_ack) a0++;
            c++;
        end
        check("rr_acks", 32'(a0), 32'd4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done(6, 400);

        // rxrdy never comes: timeout after TO wait cycles, SSO_OFF still issued
        rxrdy_en = 1'b0;
        exp_acc.push_back('{1'b0, 3'd5, 16'h0004, -1});
        exp_acc.push_back('{1'b0, 3'd3, 16'h0400, 1});
        exp_acc.push_back('{1'b0, 3'd1, 16'h0077, -1});
        exp_acc.push_back('{1'b0, 3'd3, 16'h0000, TO + 1});
        exp_ack.push_back(1'b0);
        exp_done.push_back('{1'b0, 32'h0000_0000, 1'b1});
        request(1'b0, 16'h0004, 2'd1, 32'h7788_0000);
        wait_done(7, 300);
        rxrdy_en = 1'b1;

        rx_bytes.push_back(8'h5E);
        push_txn(16'h0008, 0, 32'h9900_0000);
        exp_ack.push_back(1'b1);
        exp_done.push_back('{1'b1, 32'h0000_005E, 1'b0});
        request(1'b1, 16'h0008, 2'd0, 32'h9900_0000);
        wait_done(8, 200);

        // Request withdrawn before ack
        a0 = n_ack;
        @(negedge clk);
        req0_valid = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("withdraw_acks", 32'(n_ack), 32'(a0));
        check("withdraw_busy", {31'd0, busy}, 32'd0);

        // Reset while waiting for txrdy
        txrdy_en = 1'b0;
        exp_acc.push_back('{1'b0, 3'd5, 16'h0010, -1});
        exp_acc.push_back('{1'b0, 3'd3, 16'h0400, 1});
        exp_ack.push_back(1'b0);
        request(1'b0, 16'h0010, 2'd0, 32'hEE00_0000);
        repeat (8) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_strobes", {29'd0, spi_bus.spi_select, spi_bus.read_n, spi_bus.write_n}, 32'd3);
        check("mid_rst_addr_data", {13'd0, spi_bus.mem_addr, spi_bus.spi_wdata}, 32'd0);
        check("mid_rst_rx1", req1_rx, 32'd0);
        check("mid_rst_err0", {31'd0, req0_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        txrdy_en = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_pending_acc", 32'(exp_acc.size()), 32'd0);

        rx_bytes.push_back(8'h01); rx_bytes.push_back(8'h02);
        push_txn(16'h0020, 1, 32'hABCD_0000);
        exp_ack.push_back(1'b1);
        exp_done.push_back('{1'b1, 32'h0000_0102, 1'b0});
        request(1'b1, 16'h0020, 2'd1, 32'hABCD_0000);
        wait_done(9, 300);

        repeat (5) @(negedge clk);
        check("left_acc", 32'(exp_acc.size()), 32'd0);
        check("left_done", 32'(exp_done.size()), 32'd0);
        check("left_ack", 32'(exp_ack.size()), 32'd0);
        check("left_rx_bytes", 32'(rx_bytes.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
